// File: rtl/multiword_add_ctrl_if.sv
//------------------------------------------------------------------------------
// multiword_add_ctrl_if : operand/result handshake bundle for multiword_add_ctrl
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface multiword_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             sub;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_ovf;
  logic             busy;

  modport master (
    output start_valid, op_a, op_b, cin, sub, res_ready,
    input  start_ready, res_valid, res_sum, res_cout, res_ovf, busy
  );

  modport slave (
    input  start_valid, op_a, op_b, cin, sub, res_ready,
    output start_ready, res_valid, res_sum, res_cout, res_ovf, busy
  );
endinterface

`default_nettype wire

// File: rtl/multiword_add_ctrl.sv
//------------------------------------------------------------------------------
// multiword_add_ctrl : nibble-serial add/subtract through one shared 4-bit slice
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module FA_4bit (
  input  wire logic [3:0] a,
  input  wire logic [3:0] b,
  input  wire logic       ci,
  output logic      [3:0] s,
  output logic            co
);
  logic [4:0] c;

  assign c[0] = ci;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_bit
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign co = c[4];
endmodule

module multiword_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  wire logic           clk,
  input  wire logic           rst,
  multiword_add_ctrl_if.slave bus
);
  localparam int NIB   = WIDTH / 4;
  localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic [NIB_W-1:0] nib;

  logic [3:0] slice_s;
  logic       slice_co;
  logic       last;
  logic       start_ready;
  logic       res_valid;
  logic       busy;

  assign last = (nib == NIB_W'(NIB - 1));

  FA_4bit u_slice (
    .a  (a_reg[{nib, 2'b00} +: 4]),
    .b  (b_reg[{nib, 2'b00} +: 4]),
    .ci (carry_reg),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (bus.start_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (bus.res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1, so the inversion and the +1 happen at accept time.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      nib       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            a_reg     <= bus.op_a;
            b_reg     <= bus.sub ? ~bus.op_b : bus.op_b;
            carry_reg <= bus.sub ? 1'b1 : bus.cin;
            nib       <= '0;
          end
        end
        RUN: begin
          sum_reg[{nib, 2'b00} +: 4] <= slice_s;
          carry_reg                  <= slice_co;
          nib                        <= nib + NIB_W'(1);
          if (last) begin
            cout_reg <= slice_co;
            ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (slice_s[3] != a_reg[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.start_ready = start_ready;
  assign bus.res_valid   = res_valid;
  assign bus.busy        = busy;
  assign bus.res_sum     = sum_reg;
  assign bus.res_cout    = cout_reg;
  assign bus.res_ovf     = ovf_reg;
endmodule

`default_nettype wire

// File: tb/tb_multiword_add_ctrl.sv
//------------------------------------------------------------------------------
// tb_multiword_add_ctrl : directed self-checking bench for multiword_add_ctrl
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_multiword_add_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multiword_add_ctrl_if #(.WIDTH(16)) bus ();

  multiword_add_ctrl #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one op, completes both handshakes, returns results and accept-to-valid latency.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                        output logic [15:0] sum, output logic co, output logic ov, output int lat);
    int n;
    bus.op_a = a; bus.op_b = b; bus.cin = c; bus.sub = s; bus.start_valid = 1'b1;
    n = 0;
    while (!bus.start_ready && n < 20) begin tick(); n++; end
    tick();
    bus.start_valid = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 20) begin tick(); lat++; end
    sum = bus.res_sum; co = bus.res_cout; ov = bus.res_ovf;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (bus.start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready got %b exp 1", bus.start_ready); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", bus.res_valid); end
    checks++; if (bus.res_sum !== 16'h0000) begin errors++; $display("FAIL reset_res_sum got %h exp 0000", bus.res_sum); end
    checks++; if ({bus.res_cout, bus.res_ovf, bus.busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {bus.res_cout, bus.res_ovf, bus.busy}); end
    rst = 1'b0;
    tick();
    checks++; if (bus.start_ready !== 1'b1) begin errors++; $display("FAIL post_reset_start_ready got %b exp 1", bus.start_ready); end
  endtask

  task automatic test_add();
    logic [15:0] sum; logic co, ov; int lat;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, sum, co, ov, lat);
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL add_wrap_sum got %h exp 0000", sum); end
    checks++; if (co !== 1'b1 || ov !== 1'b0) begin errors++; $display("FAIL add_wrap_flags got co=%b ov=%b exp co=1 ov=0", co, ov); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL add_wrap_latency got %0d exp 4", lat); end
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, sum, co, ov, lat);
    checks++; if (sum !== 16'h8000) begin errors++; $display("FAIL add_ovf_sum got %h exp 8000", sum); end
    checks++; if (co !== 1'b0 || ov !== 1'b1) begin errors++; $display("FAIL add_ovf_flags got co=%b ov=%b exp co=0 ov=1", co, ov); end
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, sum, co, ov, lat);
    checks++; if (sum !== 16'h5556) begin errors++; $display("FAIL add_cin_sum got %h exp 5556", sum); end
    checks++; if (co !== 1'b0 || ov !== 1'b0) begin errors++; $display("FAIL add_cin_flags got co=%b ov=%b exp co=0 ov=0", co, ov); end
  endtask

  task automatic test_sub();
    logic [15:0] sum; logic co, ov; int lat;
    // cin=1 here must be ignored in subtract mode
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, sum, co, ov, lat);
    checks++; if (sum !== 16'hFFFE) begin errors++; $display("FAIL sub_borrow_sum got %h exp fffe", sum); end
    checks++; if (co !== 1'b0 || ov !== 1'b0) begin errors++; $display("FAIL sub_borrow_flags got co=%b ov=%b exp co=0 ov=0", co, ov); end
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, sum, co, ov, lat);
    checks++; if (sum !== 16'h7FFF) begin errors++; $display("FAIL sub_ovf_sum got %h exp 7fff", sum); end
    checks++; if (co !== 1'b1 || ov !== 1'b1) begin errors++; $display("FAIL sub_ovf_flags got co=%b ov=%b exp co=1 ov=1", co, ov); end
  endtask

  task automatic test_hold();
    int n;
    bus.op_a = 16'h00F0; bus.op_b = 16'h0F0F; bus.cin = 1'b0; bus.sub = 1'b0; bus.start_valid = 1'b1;
    n = 0;
    while (!bus.start_ready && n < 20) begin tick(); n++; end
    tick();
    bus.op_a = 16'h1111; bus.op_b = 16'h2222;
    n = 0;
    while (!bus.res_valid && n < 20) begin tick(); n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL hold_latency got %0d exp 4", n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc%0d got %b exp 1", i, bus.res_valid); end
      checks++; if ({bus.res_cout, bus.res_ovf, bus.res_sum} !== {2'b00, 16'h0FFF}) begin errors++; $display("FAIL hold_result cyc%0d got %b%b_%h exp 00_0fff", i, bus.res_cout, bus.res_ovf, bus.res_sum); end
      checks++; if (bus.start_ready !== 1'b0) begin errors++; $display("FAIL hold_start_ready cyc%0d got %b exp 0", i, bus.start_ready); end
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    checks++; if (bus.res_valid !== 1'b0 || bus.start_ready !== 1'b1) begin errors++; $display("FAIL hold_release got valid=%b ready=%b exp valid=0 ready=1", bus.res_valid, bus.start_ready); end
    tick();
    bus.start_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL hold_second_accept busy got %b exp 1", bus.busy); end
    n = 0;
    while (!bus.res_valid && n < 20) begin tick(); n++; end
    checks++; if (n !== 4 || bus.res_sum !== 16'h3333) begin errors++; $display("FAIL hold_second_result got lat=%0d sum=%h exp lat=4 sum=3333", n, bus.res_sum); end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    bus.op_a = 16'h1234; bus.op_b = 16'h1111; bus.cin = 1'b0; bus.sub = 1'b0; bus.start_valid = 1'b1;
    n = 0;
    while (!bus.start_ready && n < 20) begin tick(); n++; end
    tick();
    bus.start_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.res_sum !== 16'h0000 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL midrst_outputs got sum=%h valid=%b exp 0000/0", bus.res_sum, bus.res_valid); end
    checks++; if ({bus.res_cout, bus.res_ovf, bus.busy} !== 3'b000) begin errors++; $display("FAIL midrst_flags got %b exp 000", {bus.res_cout, bus.res_ovf, bus.busy}); end
    tick();
    checks++; if (bus.start_ready !== 1'b1) begin errors++; $display("FAIL midrst_start_ready got %b exp 1", bus.start_ready); end
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.res_valid) n++;
      tick();
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL midrst_no_result got %0d valid cycles exp 0", n); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] av[4], bv[4], ev[4];
    logic        sv[4], cv[4];
    int          n, t_acc, t_prev;
    av[0] = 16'hFFFF; bv[0] = 16'h0001; sv[0] = 1'b0; ev[0] = 16'h0000; cv[0] = 1'b1;
    av[1] = 16'h0000; bv[1] = 16'h0000; sv[1] = 1'b0; ev[1] = 16'h0000; cv[1] = 1'b0;
    av[2] = 16'h0003; bv[2] = 16'h0003; sv[2] = 1'b1; ev[2] = 16'h0000; cv[2] = 1'b1;
    av[3] = 16'h0001; bv[3] = 16'h0001; sv[3] = 1'b0; ev[3] = 16'h0002; cv[3] = 1'b0;
    bus.res_ready = 1'b1; bus.cin = 1'b0; bus.start_valid = 1'b1;
    bus.op_a = av[0]; bus.op_b = bv[0]; bus.sub = sv[0];
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!bus.start_ready && n < 20) begin tick(); n++; end
      tick();
      t_acc = cyc;
      if (i < 3) begin bus.op_a = av[i+1]; bus.op_b = bv[i+1]; bus.sub = sv[i+1]; end
      else bus.start_valid = 1'b0;
      n = 0;
      while (!bus.res_valid && n < 20) begin tick(); n++; end
      checks++; if (bus.res_sum !== ev[i] || bus.res_cout !== cv[i] || n !== 4) begin errors++; $display("FAIL b2b_op%0d got sum=%h co=%b lat=%0d exp sum=%h co=%b lat=4", i, bus.res_sum, bus.res_cout, n, ev[i], cv[i]); end
      if (i > 0) begin
        checks++; if (t_acc - t_prev !== 6) begin errors++; $display("FAIL b2b_spacing%0d got %0d cycles exp 6", i, t_acc - t_prev); end
      end
      t_prev = t_acc;
    end
    tick();
    bus.res_ready = 1'b0;
  endtask

  initial begin
    bus.start_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus.cin = 1'b0; bus.sub = 1'b0; bus.res_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
